// File: rtl/onebyfour_tdm_demultiplexer_pkg.sv
// Shared definitions for the 1:4 TDM demultiplexer: FSM encoding and slot numbering.
package onebyfour_tdm_demultiplexer_pkg;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    localparam logic [1:0] SLOT_A = 2'd0;
    localparam logic [1:0] SLOT_B = 2'd1;
    localparam logic [1:0] SLOT_C = 2'd2;
    localparam logic [1:0] SLOT_D = 2'd3;

endpackage

// File: rtl/onebyfour_demux_decoder.sv
// 2-to-4 one-hot decoder with enable; all zeros when disabled.
module onebyfour_demux_decoder (
    input  logic [1:0] sel,
    input  logic       en,
    output logic [3:0] onehot
);

    always_comb begin
        onehot = 4'b0000;
        if (en) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/onebyfour_tdm_demultiplexer.sv
// Splits a TDM word stream into four registered channels, aligned by start-of-frame,
// with update strobes, frame completion and resync error pulses.
module onebyfour_tdm_demultiplexer
    import onebyfour_tdm_demultiplexer_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    input  logic             sof,
    output logic [WIDTH-1:0] A,
    output logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] C,
    output logic [WIDTH-1:0] D,
    output logic [3:0]       vld,
    output logic [1:0]       slot,
    output logic             locked,
    output logic             frame_done,
    output logic             sync_err
);

    state_t     state;
    logic       write_en;
    logic       resync;
    logic [1:0] wr_slot;
    logic [3:0] wr_onehot;

    // sof always forces slot A; without lock only sof-marked words are taken.
    always_comb begin
        write_en = din_valid && (sof || (state == LOCKED));
        wr_slot  = sof ? SLOT_A : slot;
        resync   = din_valid && sof && (state == LOCKED) && (slot != SLOT_A);
    end

    onebyfour_demux_decoder u_decoder (
        .sel    (wr_slot),
        .en     (write_en),
        .onehot (wr_onehot)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= HUNT;
            slot       <= SLOT_A;
            A          <= '0;
            B          <= '0;
            C          <= '0;
            D          <= '0;
            vld        <= 4'b0000;
            frame_done <= 1'b0;
            sync_err   <= 1'b0;
        end else begin
            vld        <= wr_onehot;
            frame_done <= write_en && (wr_slot == SLOT_D);
            sync_err   <= resync;
            if (write_en) begin
                state <= LOCKED;
                slot  <= wr_slot + 2'd1;
            end
            if (wr_onehot[0]) A <= din;
            if (wr_onehot[1]) B <= din;
            if (wr_onehot[2]) C <= din;
            if (wr_onehot[3]) D <= din;
        end
    end

    assign locked = (state == LOCKED);

endmodule

// File: doc/onebyfour_tdm_demultiplexer.md
ONEBYFOUR_TDM_DEMULTIPLEXER -- requirements
Module: onebyfour_tdm_demultiplexer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the bit width of the input word and each channel output.
REQ-002 clk  input  1  Single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  Reset, synchronous and active-high.
REQ-004 din  input  WIDTH  Time-division-multiplexed data word.
REQ-005 din_valid  input  1  Qualifies din; when low, din and sof SHALL be ignored.
REQ-006 sof  input  1  Start-of-frame; marks the qualified word as slot 0 (channel A).
REQ-007 A, B, C, D  output  WIDTH each  Registered channel outputs for slots 0, 1, 2, 3.
REQ-008 vld  output  4  One-cycle update strobes; bit 0 = A ... bit 3 = D.
REQ-009 slot  output  2  Slot the next qualified word will be written to.
REQ-010 locked  output  1  High in state LOCKED.
REQ-011 frame_done  output  1  One-cycle pulse when a slot-3 word is accepted.
REQ-012 sync_err  output  1  One-cycle pulse when sof arrives at a nonzero slot while LOCKED.

Function
REQ-013 The FSM SHALL have two states, HUNT and LOCKED; the outputs and internal slot counter SHALL be registered.
REQ-014 In HUNT, a qualified word with sof low SHALL be discarded, with no output, strobe or slot change.
REQ-015 In HUNT, a qualified word with sof high SHALL be written to A, pulse vld[0], set slot to 1 and enter LOCKED.
REQ-016 In LOCKED, a qualified word with sof low SHALL be written to the channel selected by slot, pulse the matching vld bit, and increment slot modulo 4.
REQ-017 A qualified word accepted in slot 3 SHALL pulse frame_done in the same cycle as vld[3], and slot SHALL wrap to 0.
REQ-018 In LOCKED, sof with slot = 0 SHALL be treated as a normal slot-0 write, with no sync_err.
REQ-019 In LOCKED, sof with slot != 0 SHALL pulse sync_err, write the word to A, pulse vld[0] and set slot to 1; the partial frame SHALL NOT raise frame_done.
REQ-020 Latency from a qualified input to the channel output and strobe SHALL be exactly one clock.
REQ-021 Each channel output SHALL hold its value until that channel is next written; at most one vld bit SHALL be high in any cycle.
REQ-022 din_valid low SHALL hold slot, state and all channel outputs, and deassert vld, frame_done and sync_err.
REQ-023 Back-to-back qualified words, one per cycle, SHALL be accepted with no bubbles.

Reset
REQ-024 When rst is high at a clock edge, the block SHALL enter HUNT and clear A, B, C, D, vld, slot, locked, frame_done and sync_err to 0.
REQ-025 rst SHALL take priority over din_valid and sof in the same cycle.
REQ-026 A mid-frame reset SHALL discard the partial frame; the block SHALL then require sof to relock.

Structure
REQ-027 A shared package SHALL hold the state encoding (HUNT=0, LOCKED=1) and the slot constants SLOT_A..SLOT_D (0..3).
REQ-028 Slot-to-strobe decoding SHALL be one combinational sub-module, onebyfour_demux_decoder (2-bit select plus enable in, 4-bit one-hot out), reused for the vld generation.

Verification
REQ-029 Reset then din_valid=1, sof=1 on 8'hAA, then 8'h55, 8'hF0, 8'h0F on consecutive cycles -> A=AA, B=55, C=F0, D=0F; vld = 0001, 0010, 0100, 1000 on successive cycles; frame_done only with D; slot returns to 0.
REQ-030 In HUNT, words 8'h11 and 8'h22 with sof=0 -> A..D stay 0, vld stays 0, locked=0; a following sof on 8'h0A -> A=0A, locked=1.
REQ-031 While LOCKED, write 8'h0A, 8'h1B (slot=2), then sof on 8'h2C -> sync_err pulses, A=2C, B keeps 1B, slot=1, no frame_done.
REQ-032 Send frame 0A/1B/2C/3D, then 8'h44 with sof=0 and din_valid gaps between words -> outputs unchanged during gaps, 8'h44 lands in A (free-running frame), no sync_err.
REQ-033 Assert rst in the same cycle as a sof with 8'hFF -> all outputs 0, state HUNT, A stays 0.
REQ-034 Run with WIDTH=16: a frame of 16'hAAAA/5555/F0F0/0F0F -> routed as in REQ-029 with full width preserved.
